dsp_mac_pipe: RTL and testbench
===============================

Name: dsp_mac_pipe

Overview:
- Parametrised, fully pipelined signed pre-add / multiply / post-add MAC slice. Successor to the fixed-width DSP48A1-style slice.
- Adds a valid/ready stream handshake with backpressure, per-beat opmode carried through the pipeline, signed arithmetic and an overflow flag.
- Sits between the sample-stream front end and filter/accumulator logic. Drop-in for FIR taps and dot-product engines.

Parameters:
- A_WIDTH, 18, signed multiplier A operand width.
- B_WIDTH, 18, signed B operand width (pre-adder input).
- D_WIDTH, 18, signed D operand width (pre-adder input).
- C_WIDTH, 48, signed post-adder C operand width; must be <= P_WIDTH.
- P_WIDTH, 48, signed result width; must be >= A_WIDTH + max(B_WIDTH, D_WIDTH) + 1.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  block can accept a beat.
- A  in  A_WIDTH  signed multiplicand.
- B  in  B_WIDTH  signed pre-adder operand.
- D  in  D_WIDTH  signed pre-adder operand.
- C  in  C_WIDTH  signed post-adder operand.
- OPMODE  in  5  per-beat mode: [0] PRE_EN, [1] PRE_SUB, [3:2] ZSEL, [4] POST_SUB.
- OUT_VALID  out  1  P holds a valid result.
- OUT_READY  in  1  downstream accepts the result.
- P  out  P_WIDTH  signed result.
- M  out  A_WIDTH+max(B_WIDTH,D_WIDTH)+1  registered product of the beat currently in S4.
- OVF  out  1  result of the beat in S4 exceeded the signed P_WIDTH range.

Behaviour:
- Four register stages:
  - S1: A, B, D, C, OPMODE.
  - S2: pre-adder result, A, C, OPMODE.
  - S3: product, C, OPMODE.
  - S4: P, M, OVF.
- Each stage has a valid bit.
- ADV = ~OUT_VALID | OUT_READY. IN_READY = ADV (combinational).
- All stages and valid bits advance together only when ADV=1. No bubble collapsing.
- A beat is accepted when IN_VALID & IN_READY. Its result appears with OUT_VALID=1 exactly 4 ADV cycles later; with no stall, 4 clocks.
- Result is held stable while OUT_VALID & ~OUT_READY.
- Pre-adder, sign-extended to max(B,D)+1 bits:
  - PRE_EN=0: PRE = B.
  - PRE_EN=1, PRE_SUB=0: PRE = D + B.
  - PRE_EN=1, PRE_SUB=1: PRE = D - B.
- Multiplier: MUL = A * PRE, signed, full width, no truncation.
- ZSEL (Z operand):
  - 00: zero.
  - 01: C, sign-extended.
  - 10: current P register (accumulate).
  - 11: P + C.
- POST_SUB=0: R = Z + MUL. POST_SUB=1: R = Z - MUL.
- R is computed in P_WIDTH+2 bits. OVF=1 when R is outside [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]. P takes R[P_WIDTH-1:0] (wrap).
- P, M and OVF load only when the S3 valid bit is 1 and ADV=1. Bubbles leave P unchanged, so P always equals the last valid result.
- Back-to-back ZSEL=10 beats chain correctly: beat n in S3 sees beat n-1 in P.
- Reset (any time, including mid-stream or during a stall): all valid bits, P, M and OVF go to 0 immediately.
  - OUT_VALID=0, hence IN_READY=1.
  - In-flight beats are discarded. The accumulator restarts from 0.
- Data registers of invalid stages are don't-care internally, but P/M/OVF must never change on a bubble.
- Simultaneous accept at input and drain at output in the same cycle: both happen; full throughput is 1 beat/clock.

Optional Feature:
- Macro DSP_MAC_SAT_EN.
- Defined: on overflow, P is clamped to 2^(P_WIDTH-1)-1 (positive overflow) or -2^(P_WIDTH-1) (negative overflow). OVF is still asserted. Saturated P feeds subsequent ZSEL=10/11 beats.
- Undefined: P wraps modulo 2^P_WIDTH as above. No saturation logic is synthesised.

Test Plan:
- Basic multiply: A=3, B=-5, OPMODE=0 (ZSEL=00), OUT_READY=1 -> P=-15, M=-15, OVF=0, OUT_VALID high exactly 4 clocks after accept.
- Pre-subtract with C: A=2, D=10, B=4, C=100, PRE_EN=1, PRE_SUB=1, ZSEL=01 -> P=112. Same beat with POST_SUB=1 -> P=88.
- Accumulate chain: 4 back-to-back beats, A=1, B=1..4, ZSEL=10, starting after reset -> successive P values 1, 3, 6, 10. Repeat with a 2-cycle IN_VALID gap between beats -> same P sequence.
- Backpressure: 6 beats streamed, OUT_READY held low 5 cycles mid-stream -> IN_READY low during the stall, P held stable, no beat lost or duplicated, order preserved.
- Overflow, P_WIDTH=48: P preloaded to 2^47-1 via a C-load beat, then ZSEL=10 with A=1, B=1 -> OVF=1.
  - Without the macro: P=-2^47.
  - With DSP_MAC_SAT_EN: P=2^47-1.
- Reset mid-operation: assert RST asynchronously with 3 beats in flight and OUT_VALID=1 -> OUT_VALID, P, M, OVF = 0 immediately. A subsequent ZSEL=10 beat with A=2, B=3 -> P=6.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Four-stage signed pre-add / multiply / post-add MAC slice with a valid/ready stream handshake.
// Define DSP_MAC_SAT_EN to clamp P on overflow instead of wrapping.
module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int D_WIDTH = 18,
  parameter int C_WIDTH = 48,
  parameter int P_WIDTH = 48,
  localparam int BD_W  = (B_WIDTH > D_WIDTH) ? B_WIDTH : D_WIDTH,
  localparam int PRE_W = BD_W + 1,
  localparam int M_W   = A_WIDTH + PRE_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  input  logic signed [D_WIDTH-1:0] D,
  input  logic signed [C_WIDTH-1:0] C,
  input  logic        [4:0]         OPMODE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic signed [P_WIDTH-1:0] P,
  output logic signed [M_W-1:0]     M,
  output logic                      OVF
);

  // Two guard bits cover |Z| + |MUL| for the widest Z (P + C).
  localparam int R_W = P_WIDTH + 2;
  localparam logic signed [R_W-1:0] R_MAX = {3'b000, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [R_W-1:0] R_MIN = {3'b111, {(P_WIDTH-1){1'b0}}};

  function automatic logic ovf_det(input logic signed [R_W-1:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

`ifdef DSP_MAC_SAT_EN
  function automatic logic signed [P_WIDTH-1:0] sat_p(input logic signed [R_W-1:0] r);
    if (r > R_MAX) return R_MAX[P_WIDTH-1:0];
    if (r < R_MIN) return R_MIN[P_WIDTH-1:0];
    return r[P_WIDTH-1:0];
  endfunction
`endif

  logic adv;
  logic vld_p1, vld_p2, vld_p3;

  logic signed [A_WIDTH-1:0] a_p1, a_p2;
  logic signed [B_WIDTH-1:0] b_p1;
  logic signed [D_WIDTH-1:0] d_p1;
  logic signed [C_WIDTH-1:0] c_p1, c_p2, c_p3;
  logic        [4:0]         op_p1;
  logic        [2:0]         op_p2, op_p3;  // {POST_SUB, ZSEL}
  logic signed [PRE_W-1:0]   pre_s, pre_p2;
  logic signed [M_W-1:0]     mul_s, mul_p3;
  logic signed [R_W-1:0]     z_s, r_s;
  logic signed [P_WIDTH-1:0] p_nxt;

  // The whole pipe moves in lockstep; only a held output blocks it.
  assign adv      = ~OUT_VALID | OUT_READY;
  assign IN_READY = adv;

  // S1 -> S2: pre-adder
  always_comb begin
    pre_s = PRE_W'(b_p1);
    if (op_p1[0]) begin
      pre_s = op_p1[1] ? PRE_W'(d_p1) - PRE_W'(b_p1)
                       : PRE_W'(d_p1) + PRE_W'(b_p1);
    end
  end

  // S2 -> S3: full-width multiplier
  assign mul_s = M_W'(a_p2) * M_W'(pre_p2);

  // S3 -> S4: Z select and post-adder
  always_comb begin
    z_s = '0;
    case (op_p3[1:0])
      2'b01:   z_s = R_W'(c_p3);
      2'b10:   z_s = R_W'(P);
      2'b11:   z_s = R_W'(P) + R_W'(c_p3);
      default: z_s = '0;
    endcase
    r_s = op_p3[2] ? z_s - R_W'(mul_p3) : z_s + R_W'(mul_p3);
  end

`ifdef DSP_MAC_SAT_EN
  assign p_nxt = sat_p(r_s);
`else
  assign p_nxt = r_s[P_WIDTH-1:0];
`endif

  always_ff @(posedge CLK) begin
    if (adv) begin
      a_p1   <= A;
      b_p1   <= B;
      d_p1   <= D;
      c_p1   <= C;
      op_p1  <= OPMODE;
      pre_p2 <= pre_s;
      a_p2   <= a_p1;
      c_p2   <= c_p1;
      op_p2  <= op_p1[4:2];
      mul_p3 <= mul_s;
      c_p3   <= c_p2;
      op_p3  <= op_p2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (adv) begin
      vld_p1    <= IN_VALID;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      OUT_VALID <= vld_p3;
    end
  end

  // Result registers only move for a valid beat, so P is the last valid result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P   <= '0;
      M   <= '0;
      OVF <= 1'b0;
    end else if (adv && vld_p3) begin
      P   <= p_nxt;
      M   <= mul_p3;
      OVF <= ovf_det(r_s);
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe at default widths (18/18/18/48/48).
// Expected saturating results are selected by DSP_MAC_SAT_EN.
module tb_dsp_mac_pipe;

  logic               CLK, RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OVF;
  logic signed [17:0] A, B, D;
  logic signed [47:0] C, P;
  logic signed [36:0] M;
  logic        [4:0]  OPMODE;

  localparam longint PMAX = 64'sd140737488355327;
  localparam longint PMIN = -64'sd140737488355328;
`ifdef DSP_MAC_SAT_EN
  localparam longint OVF_POS_P = PMAX;
  localparam longint OVF_NEG_P = PMIN;
`else
  localparam longint OVF_POS_P = PMIN;
  localparam longint OVF_NEG_P = PMAX;
`endif

  typedef struct {
    logic signed [17:0] a, b, d;
    logic signed [47:0] c;
    logic        [4:0]  op;
    logic signed [47:0] p;
    logic signed [36:0] m;
    logic               ovf;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic signed [47:0] got[$];

  dsp_mac_pipe dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .D(D), .C(C), .OPMODE(OPMODE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .P(P), .M(M), .OVF(OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Every transferred result, in order.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) got.push_back(P);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(int a, int b, int d, longint c, int op,
                              longint p, longint m, int ovf);
    vec_t v;
    v.a = 18'(a); v.b = 18'(b); v.d = 18'(d); v.c = 48'(c);
    v.op = 5'(op); v.p = 48'(p); v.m = 37'(m); v.ovf = 1'(ovf);
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Presents one beat and returns at posedge+1 right after it is accepted.
  task automatic drive_beat(input logic signed [17:0] a, b, d,
                            input logic signed [47:0] c, input logic [4:0] op);
    int  n;
    bit  ok;
    A = a; B = b; D = d; C = c; OPMODE = op; IN_VALID = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge CLK);
      ok = IN_READY;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
    end
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(posedge CLK);
      #1;
      c++;
    end
    chk(name, longint'(got.size()), longint'(n));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1 RST = 1'b1;
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  vec_t   vec[14];
  longint chain_exp[4] = '{1, 3, 6, 10};
  int     lat;
  logic signed [47:0] hold;

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    A = '0; B = '0; D = '0; C = '0; OPMODE = '0;

    vec[0]  = mk(3, -5, 0, 0, 0, -15, -15, 0);
    vec[1]  = mk(2, 4, 10, 100, 7, 112, 12, 0);
    vec[2]  = mk(2, 4, 10, 100, 23, 88, 12, 0);
    vec[3]  = mk(1, 5, 0, 0, 8, 93, 5, 0);
    vec[4]  = mk(-2, 3, 0, 7, 12, 94, -6, 0);
    vec[5]  = mk(-4, -2, -3, 0, 1, 20, 20, 0);
    vec[6]  = mk(-131072, -131072, 0, 0, 0, 64'sd17179869184, 64'sd17179869184, 0);
    vec[7]  = mk(0, 0, 0, -1, 4, -1, 0, 0);
    vec[8]  = mk(0, 0, 0, PMAX, 4, PMAX, 0, 0);
    vec[9]  = mk(1, 1, 0, 0, 8, OVF_POS_P, 1, 1);
    vec[10] = mk(0, 0, 0, PMIN, 4, PMIN, 0, 0);
    vec[11] = mk(1, 1, 0, 0, 24, OVF_NEG_P, 1, 1);
    vec[12] = mk(1, 1, 0, 0, 0, 1, 1, 0);
    vec[13] = mk(3, 2, 100, 0, 2, 6, 6, 0);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out_valid", longint'(OUT_VALID), 0);
    chk("reset_in_ready", longint'(IN_READY), 1);
    chk("reset_p", longint'(P), 0);
    chk("reset_m", longint'(M), 0);
    chk("reset_ovf", longint'(OVF), 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive_beat(vec[i].a, vec[i].b, vec[i].d, vec[i].c, vec[i].op);
      IN_VALID = 1'b0;
      lat = 1;
      while (!OUT_VALID && lat < 20) begin
        @(posedge CLK);
        #1;
        lat++;
      end
      chk($sformatf("v%0d_latency", i), longint'(lat), 4);
      chk($sformatf("v%0d_p", i), longint'(P), longint'(vec[i].p));
      chk($sformatf("v%0d_m", i), longint'(M), longint'(vec[i].m));
      chk($sformatf("v%0d_ovf", i), longint'(OVF), longint'(vec[i].ovf));
      @(posedge CLK);
      #1;
    end

    // Back-to-back accumulate chain
    do_reset();
    got.delete();
    for (int k = 1; k <= 4; k++) drive_beat(18'sd1, 18'(k), 18'sd0, 48'sd0, 5'd8);
    IN_VALID = 1'b0;
    wait_got("chain_count", 4, 40);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("chain_p%0d", k), longint'(got[k]), chain_exp[k]);

    // Same chain with two idle cycles between beats
    do_reset();
    got.delete();
    for (int k = 1; k <= 4; k++) begin
      drive_beat(18'sd1, 18'(k), 18'sd0, 48'sd0, 5'd8);
      IN_VALID = 1'b0;
      repeat (2) begin
        @(posedge CLK);
        #1;
      end
    end
    wait_got("gap_count", 4, 40);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("gap_p%0d", k), longint'(got[k]), chain_exp[k]);

    // Backpressure: six beats with a five-cycle output stall mid-stream
    do_reset();
    got.delete();
    fork
      begin
        for (int k = 1; k <= 6; k++) drive_beat(18'sd1, 18'(k), 18'sd0, 48'sd0, 5'd0);
        IN_VALID = 1'b0;
      end
      begin
        repeat (5) @(posedge CLK);
        #1 OUT_READY = 1'b0;
        @(negedge CLK);
        hold = P;
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge CLK);
          chk($sformatf("stall%0d_out_valid", s), longint'(OUT_VALID), 1);
          chk($sformatf("stall%0d_in_ready", s), longint'(IN_READY), 0);
          chk($sformatf("stall%0d_p_hold", s), longint'(P), longint'(hold));
        end
        @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
    join
    wait_got("bp_count", 6, 60);
    repeat (6) begin
      @(posedge CLK);
      #1;
    end
    chk("bp_no_dup", longint'(got.size()), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      chk($sformatf("bp_p%0d", k), longint'(got[k]), longint'(k + 1));

    // Asynchronous reset with three beats in flight and a valid output
    do_reset();
    got.delete();
    for (int k = 0; k < 4; k++) drive_beat(18'sd5, 18'sd7, 18'sd0, 48'sd0, 5'd0);
    IN_VALID = 1'b0;
    chk("prerst_out_valid", longint'(OUT_VALID), 1);
    chk("prerst_p", longint'(P), 35);
    #1 RST = 1'b1;
    #1;
    chk("rst_out_valid", longint'(OUT_VALID), 0);
    chk("rst_in_ready", longint'(IN_READY), 1);
    chk("rst_p", longint'(P), 0);
    chk("rst_m", longint'(M), 0);
    chk("rst_ovf", longint'(OVF), 0);
    #1 RST = 1'b0;
    repeat (8) begin
      @(posedge CLK);
      #1;
    end
    chk("rst_flushed", longint'(got.size()), 0);
    drive_beat(18'sd2, 18'sd3, 18'sd0, 48'sd0, 5'd8);
    IN_VALID = 1'b0;
    wait_got("postrst_count", 1, 20);
    if (got.size() > 0) chk("postrst_p", longint'(got[0]), 6);
    chk("postrst_m", longint'(M), 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
